// File: rtl/adder_sweep_pkg.sv
// Shared widths, FSM encodings and the golden adder model for the adder sweep checker.
package adder_sweep_pkg;

  localparam int VEC_W = 9;
  localparam int SUM_W = 5;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Reference result of the adder under test; its carry-in is active-low.
  function automatic logic [SUM_W-1:0] golden_sum(input logic [3:0] a,
                                                  input logic [3:0] b,
                                                  input logic       cin_n);
    return {1'b0, a} + {1'b0, b} + {4'b0000, ~cin_n};
  endfunction

endpackage

// File: rtl/adder_sweep_checker_if.sv
// Stimulus/response bus between the sweep checker (master) and the 4-bit adder (slave).
interface adder_sweep_checker_if;
  logic [3:0] A_o;
  logic [3:0] B_o;
  logic       Cin_o;
  logic [3:0] F_s;
  logic       Cout_s;
  logic [3:0] F_p;
  logic       Cout_p;

  modport master (output A_o, B_o, Cin_o, input  F_s, Cout_s, F_p, Cout_p);
  modport slave  (input  A_o, B_o, Cin_o, output F_s, Cout_s, F_p, Cout_p);
endinterface

// File: rtl/adder_sweep_checker_vector_gen.sv
// Vector index counter plus settle timer; strobes the check on the last cycle of each hold window.
module sweep_vector_gen
  import adder_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [VEC_W-1:0] vec,
  output logic             check_strobe,
  output logic             last
);

  localparam logic [3:0] TMR_END = 4'(SETTLE_CYCLES);

  logic [3:0] tmr;

  assign check_strobe = en && (tmr == TMR_END);
  assign last         = check_strobe && (&vec);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vec <= '0;
      tmr <= '0;
    end else if (en) begin
      if (tmr == TMR_END) begin
        tmr <= '0;
        vec <= vec + 9'd1;
      end else begin
        tmr <= tmr + 4'd1;
      end
    end
  end

endmodule

// File: rtl/adder_sweep_checker.sv
// Exhaustive self-test of the 4-bit adder: sweeps {Cin,B,A}, compares serial vs parallel results.
// Define SWEEP_GOLDEN_EN to also check both paths against an internal golden sum.
module adder_sweep_checker
  import adder_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  adder_sweep_checker_if.master   bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [9:0]              err_count,
  output logic [VEC_W-1:0]        fail_vec,
  output logic                    fail_valid
);

  logic [1:0]       state;
  logic             go;
  logic             run;
  logic [VEC_W-1:0] vec;
  logic             check_strobe;
  logic             last;
  logic             vec_bad;
  logic [SUM_W-1:0] ser_sum;
  logic [SUM_W-1:0] par_sum;

  assign run = (state == ST_RUN);
  // start is only honoured from the two resting states
  assign go  = start && ((state == ST_IDLE) || (state == ST_DONE));

  sweep_vector_gen #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_vgen (
    .clk          (clk),
    .rst          (rst),
    .clear        (go),
    .en           (run),
    .vec          (vec),
    .check_strobe (check_strobe),
    .last         (last)
  );

  assign bus.A_o   = run ? vec[3:0] : 4'd0;
  assign bus.B_o   = run ? vec[7:4] : 4'd0;
  assign bus.Cin_o = run ? vec[8]   : 1'b0;

  assign ser_sum = {bus.Cout_s, bus.F_s};
  assign par_sum = {bus.Cout_p, bus.F_p};

`ifdef SWEEP_GOLDEN_EN
  logic [SUM_W-1:0] exp_sum;
  assign exp_sum = golden_sum(vec[3:0], vec[7:4], vec[8]);
  assign vec_bad = (ser_sum != par_sum) || (par_sum != exp_sum) || (ser_sum != exp_sum);
`else
  assign vec_bad = (ser_sum != par_sum);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state <= ST_RUN;
        ST_RUN:           if (last)  state <= ST_DONE;
        default:          state <= ST_IDLE;
      endcase

      if (go) begin
        err_count  <= '0;
        fail_vec   <= '0;
        fail_valid <= 1'b0;
      end else if (check_strobe && vec_bad) begin
        err_count <= err_count + 10'd1;
        // keep only the first failure of the sweep
        if (!fail_valid) begin
          fail_vec   <= vec;
          fail_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = run;
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == 10'd0);

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Directed bench for adder_sweep_checker: behavioural adder with selectable faults, two DUT settle depths.
module tb_adder_sweep_checker;

  logic clk = 1'b0;
  logic rst, start, start0;
  always #5 clk = ~clk;

  adder_sweep_checker_if bus ();
  adder_sweep_checker_if bus0 ();

  logic       busy, done, pass, fail_valid;
  logic [9:0] err_count;
  logic [8:0] fail_vec;
  logic       busy0, done0, pass0, fail_valid0;
  logic [9:0] err_count0;
  logic [8:0] fail_vec0;

  adder_sweep_checker #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_vec(fail_vec), .fail_valid(fail_valid)
  );

  adder_sweep_checker #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
    .fail_vec(fail_vec0), .fail_valid(fail_valid0)
  );

  // 0 correct, 1 parallel bit0 stuck 0, 2 both paths use A+B+Cin, 3 serial wrong on vector 0x1A5
  int mode;
  int n_run, n_fail;
  int cyc;
  logic [4:0] sum_ok, sum_inv, sum0;

  always_comb begin
    sum_ok  = {1'b0, bus.A_o} + {1'b0, bus.B_o} + {4'b0000, ~bus.Cin_o};
    sum_inv = {1'b0, bus.A_o} + {1'b0, bus.B_o} + {4'b0000, bus.Cin_o};
    {bus.Cout_s, bus.F_s} = sum_ok;
    {bus.Cout_p, bus.F_p} = sum_ok;
    case (mode)
      1: bus.F_p = {sum_ok[3:1], 1'b0};
      2: begin
        {bus.Cout_s, bus.F_s} = sum_inv;
        {bus.Cout_p, bus.F_p} = sum_inv;
      end
      3: if ({bus.Cin_o, bus.B_o, bus.A_o} == 9'h1A5) bus.F_s = sum_ok[3:0] ^ 4'b1000;
      default: ;
    endcase
  end

  always_comb begin
    sum0 = {1'b0, bus0.A_o} + {1'b0, bus0.B_o} + {4'b0000, ~bus0.Cin_o};
    {bus0.Cout_s, bus0.F_s} = sum0;
    {bus0.Cout_p, bus0.F_p} = sum0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns in the first RUN cycle
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to_done(input bit noisy);
    while (!done && cyc < 2000) begin
      start = noisy && ((cyc % 97) == 5);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.A_o, bus.B_o, bus.Cin_o, busy, done, pass, err_count, fail_vec, fail_valid};
  endfunction

  initial begin
    n_run = 0; n_fail = 0; mode = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; start0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // clean sweep from IDLE
    pulse_start();
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_vec0", {23'd0, bus.Cin_o, bus.B_o, bus.A_o}, 32'd0);
    run_to_done(1'b0);
    chk("ok_latency", cyc, 32'd1536);
    chk("ok_pass", {30'd0, pass, busy}, 32'd2);
    chk("ok_err", {21'd0, fail_valid, err_count}, 32'd0);
    repeat (5) @(negedge clk);
    chk("done_hold", {31'd0, done}, 32'd1);
    chk("done_vec0", {23'd0, bus.Cin_o, bus.B_o, bus.A_o}, 32'd0);

    // stuck parallel bit0, restarted from DONE
    mode = 1;
    pulse_start();
    chk("restart_clr", {29'd0, done, fail_valid, busy}, 32'd1);
    chk("restart_err", {22'd0, err_count}, 32'd0);
    run_to_done(1'b0);
    chk("stuck_latency", cyc, 32'd1536);
    chk("stuck_err", {22'd0, err_count}, 32'd256);
    chk("stuck_fvec", {22'd0, fail_valid, fail_vec}, 32'h200);
    chk("stuck_pass", {31'd0, pass}, 32'd0);

    // carry polarity inverted on both paths
    mode = 2;
    pulse_start();
    run_to_done(1'b0);
`ifdef SWEEP_GOLDEN_EN
    chk("inv_err", {22'd0, err_count}, 32'd512);
    chk("inv_pass", {31'd0, pass}, 32'd0);
`else
    chk("inv_err", {22'd0, err_count}, 32'd0);
    chk("inv_pass", {31'd0, pass}, 32'd1);
`endif

    // single serial error on vector 0x1A5; vector mapping seen mid-sweep
    mode = 3;
    pulse_start();
    repeat (1263) @(negedge clk);
    cyc = 1263;
    chk("map_1a5", {23'd0, bus.Cin_o, bus.B_o, bus.A_o}, 32'h1A5);
    chk("map_a_b", {24'd0, bus.B_o, bus.A_o}, 32'hA5);
    chk("one_err_pre", {22'd0, err_count}, 32'd0);
    run_to_done(1'b0);
    chk("one_err", {22'd0, err_count}, 32'd1);
    chk("one_fvec", {22'd0, fail_valid, fail_vec}, 32'h3A5);

    // reset on RUN cycle 100 after some errors have accumulated
    mode = 1;
    pulse_start();
    repeat (99) @(negedge clk);
    chk("mid_err", {22'd0, err_count}, 32'd17);
    chk("mid_fvec", {22'd0, fail_valid, fail_vec}, 32'h200);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", all_outs(), 32'd0);
    rst = 1'b0;
    mode = 0;
    @(negedge clk);
    chk("idle_after_rst", {30'd0, busy, done}, 32'd0);
    pulse_start();
    run_to_done(1'b0);
    chk("rerun_latency", cyc, 32'd1536);
    chk("rerun_pass", {31'd0, pass}, 32'd1);

    // start pulses during RUN must not disturb the sweep
    pulse_start();
    run_to_done(1'b1);
    chk("noisy_latency", cyc, 32'd1536);
    chk("noisy_pass", {21'd0, pass, err_count}, 32'h400);

    // zero settle cycles
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 0;
    chk("s0_busy", {31'd0, busy0}, 32'd1);
    while (!done0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("s0_latency", cyc, 32'd512);
    chk("s0_pass", {20'd0, pass0, fail_valid0, err_count0}, 32'h800);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_sweep_checker.md
# adder_sweep_checker

Self-test sequencer that drives the four-bit adder block with every input combination and checks its outputs. It sits directly upstream and downstream of the adder: it generates `A`, `B` and `Cin` for the adder, consumes the serial outputs (`F_s`, `Cout_s`) and parallel outputs (`F_p`, `Cout_p`), and reports a pass/fail summary to the board-level display logic. The adder's `Cin` is active-low: the adder computes `A + B + ~Cin`.

## Interface
- `SETTLE_CYCLES`, default 2: number of cycles each vector is held before its outputs are sampled; legal range 0..15.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  pulse that begins a sweep; honoured only in IDLE or DONE.
- `A_o`  out  4  operand A to the adder.
- `B_o`  out  4  operand B to the adder.
- `Cin_o`  out  1  active-low carry-in to the adder.
- `F_s`  in  4  serial adder sum.
- `Cout_s`  in  1  serial adder carry-out.
- `F_p`  in  4  parallel adder sum.
- `Cout_p`  in  1  parallel adder carry-out.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE; held until the next `start` or `rst`.
- `pass`  out  1  `done && err_count == 0`.
- `err_count`  out  10  number of failing vectors (0..512).
- `fail_vec`  out  9  first failing vector index, `{Cin,B,A}`.
- `fail_valid`  out  1  `fail_vec` holds a captured vector.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start`. DONE → RUN on `start`.
- RUN → DONE after vector 511 is checked.
- `start` is ignored while in RUN.
- Entering RUN clears the vector index, settle timer, `err_count`, `fail_vec` and `fail_valid`.
- Vector index `i[8:0]` counts from 0 to 511, mapped as `A_o = i[3:0]`, `B_o = i[7:4]`, `Cin_o = i[8]`. `A_o`, `B_o` and `Cin_o` are 0 outside RUN.
- Each vector is held for `SETTLE_CYCLES + 1` cycles and checked on the last cycle.
- A vector fails if `{Cout_s,F_s} != {Cout_p,F_p}`, or if the golden check fails (see Configuration).
- On a failing vector, `err_count` increments by 1. No saturation is needed: the maximum is 512.
- `fail_vec` and `fail_valid` are captured only on the first failure of a sweep.
- `rst` at any point, including mid-sweep, forces IDLE and zeroes every output and register on the next edge.
- Reset values: `A_o`, `B_o`, `Cin_o`, `busy`, `done`, `pass`, `err_count`, `fail_vec` and `fail_valid` are all 0.

## Timing
- `start` sampled at edge k puts the FSM in RUN after edge k; vector 0 is on `A_o`/`B_o`/`Cin_o` and `busy=1` in the cycle after edge k.
- Adder outputs are sampled at the edge ending the hold window. The check result is registered at that same edge, so it is visible in `err_count` one cycle later.
- `done=1` and `busy=0` appear `512*(SETTLE_CYCLES+1)` cycles after the first RUN cycle: 1536 cycles for the default `SETTLE_CYCLES=2`.
- `pass`, `err_count` and `fail_vec` are final when `done` rises.
- A `start` in DONE gives the same timing as a `start` in IDLE.

## Configuration
- Macro `SWEEP_GOLDEN_EN`.
- Defined: an internal golden model computes `exp = A + B + ~Cin` as a 5-bit value. A vector also fails if `{Cout_p,F_p} != exp` or `{Cout_s,F_s} != exp`.
- Undefined: only the serial-versus-parallel equality check is performed, and the golden logic is not synthesised.

## Structure
- Package `adder_sweep_pkg` holds:
  - `VEC_W = 9` and `SUM_W = 5`.
  - The FSM state enum.
  - The function `golden_sum(a,b,cin_n)`.
- One sub-module, `sweep_vector_gen`, contains:
  - the vector index counter and the settle timer;
  - outputs `vec[8:0]`, `check_strobe` and `last`.
- The top level contains the FSM, the comparators and the result registers.

## Test plan
- Correct behavioural adder on both paths, `SETTLE_CYCLES=2`, `start` pulse → `done` 1536 cycles after RUN entry; `pass=1`, `err_count=0`, `fail_valid=0`.
- Parallel sum bit 0 stuck at 0 → `err_count=256`, `fail_vec=9'h000`, `fail_valid=1`, `pass=0`.
- Both paths compute `A+B+Cin` (carry polarity inverted):
  - with `SWEEP_GOLDEN_EN` → `err_count=512`, `pass=0`;
  - without it → `err_count=0`, `pass=1`.
- Assert `rst` on cycle 100 of RUN → next cycle all outputs are 0 and the FSM is in IDLE. A new `start` then completes with `pass=1`.
- Pulse `start` repeatedly during RUN → timing is unchanged. A `start` in DONE clears `done`, `err_count` and `fail_valid` and reruns the full sweep.
- `SETTLE_CYCLES=0` with correct adders → `done` after 512 cycles, `pass=1`.
